// File: rtl/calc_if.sv
// Bus between the calculator entry logic and the execute unit: entry word and
// start request in, BCD result digits and status flags out.
interface calc_if;
    logic [18:0] i_Inputs;
    logic        i_Start;
    logic        o_Busy;
    logic        o_Done;
    logic [3:0]  o_Result_Tens;
    logic [3:0]  o_Result_Ones;
    logic        o_Negative;
    logic        o_Overflow;
    logic        o_Div_Zero;
    logic        o_Invalid;

    // Start is a single-cycle request, honoured only while o_Busy is low; o_Done
    // pulses for one cycle when the digits and flags take their new values.
    modport master (
        output i_Inputs, i_Start,
        input  o_Busy, o_Done, o_Result_Tens, o_Result_Ones,
        input  o_Negative, o_Overflow, o_Div_Zero, o_Invalid
    );

    modport slave (
        input  i_Inputs, i_Start,
        output o_Busy, o_Done, o_Result_Tens, o_Result_Ones,
        output o_Negative, o_Overflow, o_Div_Zero, o_Invalid
    );
endinterface

// File: rtl/calc_execute_unit.sv
// Calculator execute stage: BCD operands to binary, sequential add/sub/mul/div,
// double-dabble back to two BCD digits, with overflow/div-zero/invalid flags.
module calc_execute_unit (
    input  logic   i_Clk,
    input  logic   i_Reset,
    calc_if.slave  bus
);
    typedef enum logic [2:0] {S_IDLE, S_CONVERT, S_COMPUTE, S_BCD, S_DONE} state_e;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;

    state_e      state_q, state_d;
    logic [18:0] inputs_q, inputs_d;
    logic [2:0]  op_q, op_d;
    logic [6:0]  a_q, a_d, b_q, b_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [13:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [6:0]  rem_q, rem_d;
    logic        neg_q, neg_d;
    logic [7:0]  bcd_q, bcd_d;
    logic [6:0]  bin_q, bin_d;
    logic [3:0]  tens_q, tens_d, ones_q, ones_d;
    logic        neg_out_q, neg_out_d, ovf_q, ovf_d, dz_q, dz_d, inv_q, inv_d;

    logic [6:0]  a_bin, b_bin;
    logic        digit_bad, op_bad, finish;
    logic [7:0]  rem_sh;
    logic [3:0]  tens_adj, ones_adj;

    assign a_bin = 7'(inputs_q[18:15]) * 7'd10 + 7'(inputs_q[14:11]);
    assign b_bin = 7'(inputs_q[7:4]) * 7'd10 + 7'(inputs_q[3:0]);
    assign digit_bad = (inputs_q[18:15] > 4'd9) || (inputs_q[14:11] > 4'd9) ||
                       (inputs_q[7:4] > 4'd9) || (inputs_q[3:0] > 4'd9);
    assign op_bad = (inputs_q[10:8] < OP_ADD) || (inputs_q[10:8] > OP_DIV);
    assign rem_sh = {rem_q, a_q[6]};
    assign tens_adj = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    assign ones_adj = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];

    always_comb begin
        state_d   = state_q;
        inputs_d  = inputs_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        rem_d     = rem_q;
        neg_d     = neg_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        neg_out_d = neg_out_q;
        ovf_d     = ovf_q;
        dz_d      = dz_q;
        inv_d     = inv_q;
        finish    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.i_Start) begin
                    inputs_d = bus.i_Inputs;
                    state_d  = S_CONVERT;
                end
            end
            S_CONVERT: begin
                op_d    = inputs_q[10:8];
                a_d     = a_bin;
                b_d     = b_bin;
                cnt_d   = 3'd0;
                acc_d   = 14'd0;
                rem_d   = 7'd0;
                mcand_d = 14'(a_bin);
                neg_d   = 1'b0;
                if (digit_bad || op_bad || (inputs_q[10:8] == OP_DIV && b_bin == 7'd0)) begin
                    tens_d    = 4'd0;
                    ones_d    = 4'd0;
                    neg_out_d = 1'b0;
                    ovf_d     = 1'b0;
                    inv_d     = digit_bad || op_bad;
                    dz_d      = !(digit_bad || op_bad);
                    state_d   = S_DONE;
                end else begin
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                cnt_d = cnt_q + 3'd1;
                case (op_q)
                    OP_ADD: begin
                        acc_d  = 14'(a_q) + 14'(b_q);
                        finish = 1'b1;
                    end
                    OP_SUB: begin
                        neg_d  = (a_q < b_q);
                        acc_d  = (a_q < b_q) ? 14'(b_q - a_q) : 14'(a_q - b_q);
                        finish = 1'b1;
                    end
                    OP_MUL: begin
                        if (b_q[0]) acc_d = acc_q + mcand_q;
                        mcand_d = mcand_q << 1;
                        b_d     = b_q >> 1;
                        finish  = (cnt_q == 3'd6);
                    end
                    default: begin
                        // Restoring division: dividend bits enter the remainder MSB first.
                        if (rem_sh >= {1'b0, b_q}) begin
                            rem_d = 7'(rem_sh - {1'b0, b_q});
                            acc_d = {acc_q[12:0], 1'b1};
                        end else begin
                            rem_d = rem_sh[6:0];
                            acc_d = {acc_q[12:0], 1'b0};
                        end
                        a_d    = a_q << 1;
                        finish = (cnt_q == 3'd6);
                    end
                endcase
                if (finish) begin
                    cnt_d = 3'd0;
                    if (acc_d > 14'd99) begin
                        tens_d    = 4'd0;
                        ones_d    = 4'd0;
                        neg_out_d = 1'b0;
                        ovf_d     = 1'b1;
                        dz_d      = 1'b0;
                        inv_d     = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        bin_d   = acc_d[6:0];
                        bcd_d   = 8'd0;
                        state_d = S_BCD;
                    end
                end
            end
            S_BCD: begin
                bcd_d = {tens_adj[2:0], ones_adj, bin_q[6]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd6) begin
                    tens_d    = bcd_d[7:4];
                    ones_d    = bcd_d[3:0];
                    neg_out_d = neg_q;
                    ovf_d     = 1'b0;
                    dz_d      = 1'b0;
                    inv_d     = 1'b0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            inputs_q  <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            rem_q     <= '0;
            neg_q     <= 1'b0;
            bcd_q     <= '0;
            bin_q     <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            neg_out_q <= 1'b0;
            ovf_q     <= 1'b0;
            dz_q      <= 1'b0;
            inv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inputs_q  <= inputs_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            rem_q     <= rem_d;
            neg_q     <= neg_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            neg_out_q <= neg_out_d;
            ovf_q     <= ovf_d;
            dz_q      <= dz_d;
            inv_q     <= inv_d;
        end
    end

    assign bus.o_Busy        = (state_q != S_IDLE);
    assign bus.o_Done        = (state_q == S_DONE);
    assign bus.o_Result_Tens = tens_q;
    assign bus.o_Result_Ones = ones_q;
    assign bus.o_Negative    = neg_out_q;
    assign bus.o_Overflow    = ovf_q;
    assign bus.o_Div_Zero    = dz_q;
    assign bus.o_Invalid     = inv_q;
endmodule

// File: tb/tb_calc_execute_unit.sv
// Self-checking bench for calc_execute_unit: directed cases followed by random
// entry words, each checked against an arithmetic reference model.
module tb_calc_execute_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    calc_if bus ();

    calc_execute_unit dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] mk(input int at, input int ao, input int op,
                                       input int bt, input int bo);
        return {4'(at), 4'(ao), 3'(op), 4'(bt), 4'(bo)};
    endfunction

    // Outputs packed as {tens, ones, negative, overflow, div_zero, invalid}.
    function automatic logic [11:0] obs_vec();
        return {bus.o_Result_Tens, bus.o_Result_Ones, bus.o_Negative,
                bus.o_Overflow, bus.o_Div_Zero, bus.o_Invalid};
    endfunction

    // lat = spec cycle index of o_Done relative to the accept edge.
    function automatic void model(input logic [18:0] w, output logic [11:0] e, output int lat);
        int at, ao, bt, bo, op, a, b, r, c;
        at = int'(w[18:15]); ao = int'(w[14:11]); op = int'(w[10:8]);
        bt = int'(w[7:4]);   bo = int'(w[3:0]);
        if (at > 9 || ao > 9 || bt > 9 || bo > 9 || op < 1 || op > 4) begin
            e = 12'b0000_0000_0001; lat = 2; return;
        end
        a = at * 10 + ao;
        b = bt * 10 + bo;
        if (op == 4 && b == 0) begin
            e = 12'b0000_0000_0010; lat = 2; return;
        end
        case (op)
            1: r = a + b;
            2: r = (a < b) ? b - a : a - b;
            3: r = a * b;
            default: r = a / b;
        endcase
        c = (op <= 2) ? 1 : 7;
        if (r > 99) begin
            e = 12'b0000_0000_0100; lat = 2 + c; return;
        end
        e = {4'(r / 10), 4'(r % 10), (op == 2 && a < b), 3'b000};
        lat = 9 + c;
    endfunction

    task automatic run_op(input logic [18:0] w, input string tag, input int inject_at);
        logic [11:0] e;
        int lat, edges;
        model(w, e, lat);
        @(negedge clk);
        bus.i_Inputs = w;
        bus.i_Start  = 1'b1;
        @(posedge clk); #1;
        bus.i_Start  = 1'b0;
        bus.i_Inputs = 19'($urandom);
        chk({tag, ".busy_after_accept"}, 32'(bus.o_Busy), 32'd1);
        edges = 0;
        while (bus.o_Done !== 1'b1 && edges < 40) begin
            if (edges == inject_at - 1) begin
                bus.i_Start  = 1'b1;
                bus.i_Inputs = 19'($urandom);
            end
            @(posedge clk); #1;
            bus.i_Start = 1'b0;
            edges++;
        end
        chk({tag, ".done_latency"}, 32'(edges + 1), 32'(lat));
        chk({tag, ".busy_in_done"}, 32'(bus.o_Busy), 32'd1);
        chk({tag, ".result"}, 32'(obs_vec()), 32'(e));
        // A start during the DONE cycle must not be accepted.
        bus.i_Start  = 1'b1;
        bus.i_Inputs = 19'($urandom);
        @(posedge clk); #1;
        bus.i_Start = 1'b0;
        chk({tag, ".done_cleared"}, 32'(bus.o_Done), 32'd0);
        chk({tag, ".idle_after_done"}, 32'(bus.o_Busy), 32'd0);
        chk({tag, ".result_hold"}, 32'(obs_vec()), 32'(e));
    endtask

    initial begin
        int at, ao, op, bt, bo, done_seen;
        bus.i_Inputs = '0;
        bus.i_Start  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 32'(bus.o_Busy), 32'd0);
        chk("reset.done", 32'(bus.o_Done), 32'd0);
        chk("reset.outputs", 32'(obs_vec()), 32'd0);
        rst = 1'b0;

        run_op(mk(1, 2, 1, 3, 4), "add_12_34", -1);
        run_op(mk(9, 9, 1, 0, 1), "add_99_01_ovf", -1);
        run_op(mk(0, 5, 2, 1, 7), "sub_05_17_neg", -1);
        run_op(mk(1, 7, 2, 0, 5), "sub_17_05", -1);
        run_op(mk(1, 2, 3, 0, 9), "mul_12_09_ovf", -1);
        run_op(mk(0, 7, 3, 1, 3), "mul_07_13", -1);
        run_op(mk(8, 7, 4, 0, 4), "div_87_04", -1);
        run_op(mk(9, 9, 4, 0, 0), "div_99_00_dz", -1);
        run_op(mk(10, 2, 1, 3, 4), "inv_digit", -1);
        run_op(mk(1, 2, 7, 3, 4), "inv_op", -1);
        run_op(mk(0, 0, 0, 0, 0), "inv_op0", -1);
        run_op(mk(1, 2, 3, 0, 8), "mul_12_08_restart_ignored", 5);

        // Reset in the middle of a multiply.
        @(negedge clk);
        bus.i_Inputs = mk(0, 7, 3, 1, 3);
        bus.i_Start  = 1'b1;
        @(posedge clk); #1;
        bus.i_Start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset.busy", 32'(bus.o_Busy), 32'd0);
        chk("midreset.done", 32'(bus.o_Done), 32'd0);
        chk("midreset.outputs", 32'(obs_vec()), 32'd0);
        done_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.o_Done) done_seen++;
        end
        chk("midreset.no_done", 32'(done_seen), 32'd0);
        run_op(mk(2, 3, 3, 0, 4), "post_reset_mul_23_04", -1);

        for (int i = 0; i < 30; i++) begin
            at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
            ao = int'($urandom_range(0, 9));
            bt = int'($urandom_range(0, 9));
            bo = int'($urandom_range(0, 9));
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4));
            if ($urandom_range(0, 5) == 0) begin bt = 0; bo = 0; end
            run_op(mk(at, ao, op, bt, bo), $sformatf("rand%0d", i), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
